// File: rtl/spi_slave_fsm.sv
// SPI slave serial front end: deserialises 10-bit command frames for the RAM and
// shifts RAM read data out on MISO. Define SPI_CMD_CHECK_EN to enable opcode checking.
module spi_slave_fsm #(
  parameter int ADDR_SIZE  = 8,
  parameter int MEM_WIDTH  = 8,
  parameter int TX_TIMEOUT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [MEM_WIDTH-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 err
);

  localparam int FRAME_BITS = ADDR_SIZE + 2;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  localparam int WAIT_W     = $clog2(TX_TIMEOUT + 1);
  localparam int BIT_W      = $clog2(MEM_WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  // Sub-phases of READ_DATA once the command frame has been accepted.
  typedef enum logic [1:0] {
    TX_OFF,
    TX_WAIT,
    TX_SHIFT,
    TX_DONE
  } tx_phase_t;

  state_t                  state, next_state;
  tx_phase_t               tx_phase;
  logic [CNT_W-1:0]        count;
  logic [FRAME_BITS-2:0]   shift_reg;
  logic [FRAME_BITS-1:0]   frame_word;
  logic                    rd_addr_seen;
  logic [WAIT_W-1:0]       wait_cnt;
  logic [BIT_W-1:0]        bit_cnt;
  logic [MEM_WIDTH-1:0]    tx_shift;

  logic in_rx;
  logic sample_bit;
  logic last_bit;
  logic abort;
  logic cmd_ok;
  logic frame_ok;

  assign frame_word = {shift_reg, MOSI};

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential blocks use non-blocking (<=) so every flop sees pre-edge values.
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    next_state = state;
    unique case (state)
      IDLE: begin
        if (!SS_n) next_state = CHK_CMD;
      end
      CHK_CMD: begin
        if (SS_n)              next_state = IDLE;
        else if (!MOSI)        next_state = WRITE;
        else if (rd_addr_seen) next_state = READ_DATA;
        else                   next_state = READ_ADD;
      end
      WRITE, READ_ADD, READ_DATA: begin
        if (SS_n) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Control decode
  always_comb begin
    in_rx      = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);
    abort      = SS_n && (state != IDLE);
    sample_bit = !SS_n &&
                 ((state == CHK_CMD) || (in_rx && (count < CNT_W'(FRAME_BITS))));
    last_bit   = sample_bit && in_rx && (count == CNT_W'(FRAME_BITS - 1));
  end

`ifdef SPI_CMD_CHECK_EN
  logic partial_abort;

  always_comb begin
    cmd_ok = 1'b1;
    unique case (state)
      WRITE:     cmd_ok = !frame_word[FRAME_BITS-1];
      READ_ADD:  cmd_ok = (frame_word[FRAME_BITS-1 -: 2] == 2'b10);
      READ_DATA: cmd_ok = (frame_word[FRAME_BITS-1 -: 2] == 2'b11);
      default:   cmd_ok = 1'b1;
    endcase
  end

  // Only frames with at least one bit received count as partial.
  assign partial_abort = abort && in_rx && (count < CNT_W'(FRAME_BITS));
`else
  assign cmd_ok = 1'b1;
`endif

  assign frame_ok = last_bit && cmd_ok;

  // Datapath: receive shifter, command output, transmit sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      count        <= '0;
      shift_reg    <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      err          <= 1'b0;
      MISO         <= 1'b0;
      rd_addr_seen <= 1'b0;
      tx_phase     <= TX_OFF;
      wait_cnt     <= '0;
      bit_cnt      <= '0;
      tx_shift     <= '0;
    end else begin
      rx_valid <= 1'b0;
      err      <= 1'b0;

      if (sample_bit) begin
        shift_reg <= frame_word[FRAME_BITS-2:0];
        count     <= count + 1'b1;
      end

      if (frame_ok) begin
        rx_data  <= frame_word;
        rx_valid <= 1'b1;
        if (state == READ_ADD) rd_addr_seen <= 1'b1;
        if (state == READ_DATA) begin
          tx_phase <= TX_WAIT;
          wait_cnt <= '0;
        end
      end

`ifdef SPI_CMD_CHECK_EN
      if ((last_bit && !cmd_ok) || partial_abort) err <= 1'b1;
`endif

      if ((state == READ_DATA) && !SS_n) begin
        unique case (tx_phase)
          TX_WAIT: begin
            if (tx_valid) begin
              tx_shift <= tx_data;
              bit_cnt  <= '0;
              tx_phase <= TX_SHIFT;
            end else if (wait_cnt == WAIT_W'(TX_TIMEOUT - 1)) begin
              tx_phase     <= TX_DONE;
              rd_addr_seen <= 1'b0;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
          TX_SHIFT: begin
            if (bit_cnt == BIT_W'(MEM_WIDTH)) begin
              MISO         <= 1'b0;
              tx_phase     <= TX_DONE;
              rd_addr_seen <= 1'b0;
            end else begin
              MISO     <= tx_shift[MEM_WIDTH-1];
              tx_shift <= {tx_shift[MEM_WIDTH-2:0], 1'b0};
              bit_cnt  <= bit_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end

      if (abort || (state == IDLE)) begin
        count    <= '0;
        tx_phase <= TX_OFF;
        MISO     <= 1'b0;
      end

      // A read-data command that was accepted consumes the stored address even if cut short.
      if (abort && (state == READ_DATA) && (tx_phase != TX_OFF)) rd_addr_seen <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_slave_fsm.sv
// Self-checking bench for spi_slave_fsm: directed protocol scenarios plus randomized
// frames checked against a transaction-level model of the slave.
module tb_spi_slave_fsm;

  localparam int TX_TIMEOUT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       err;

  int checks = 0;
  int errors = 0;
  bit rd_seen;  // model: a read address is pending

  spi_slave_fsm #(.ADDR_SIZE(8), .MEM_WIDTH(8), .TX_TIMEOUT(TX_TIMEOUT)) dut (
    .clk      (clk),
    .rst      (rst),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Whether a completed frame is accepted, given the pending-address state.
  function automatic bit frame_accepted(input logic [9:0] w, input bit seen);
`ifdef SPI_CMD_CHECK_EN
    if (!w[9]) return 1'b1;
    if (!seen) return (w[8] == 1'b0);
    return (w[8] == 1'b1);
`else
    return 1'b1;
`endif
  endfunction

  function automatic bit err_expected_on_partial();
`ifdef SPI_CMD_CHECK_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Full frame, then 16 tail cycles. tx_valid is offered d cycles after frame
  // completion (d=0: never). abort_at>0 raises SS_n on that tail cycle.
  task automatic full_frame(input logic [9:0] w, input int d, input int abort_at,
                            input logic [7:0] val);
    bit   ok;
    bit   is_rd;
    logic exp_miso;
    ok    = frame_accepted(w, rd_seen);
    is_rd = w[9] && rd_seen;
    SS_n  = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      MOSI     = w[9-i];
      tx_valid = 1'($urandom);
      tx_data  = 8'($urandom);
      tick();
      if (i < 9) check("rx_valid_mid_frame", rx_valid, 0);
    end
    check("rx_valid_strobe", rx_valid, ok);
    if (ok) check("rx_data", rx_data, w);
    check("err_on_frame", err, !ok);
    if (ok && w[9] && !rd_seen) rd_seen = 1'b1;

    for (int t = 1; t <= 16; t++) begin
      MOSI     = 1'($urandom);
      tx_valid = (t == d);
      tx_data  = (t == d) ? val : 8'($urandom);
      if (t == abort_at) SS_n = 1'b1;
      tick();
      exp_miso = 1'b0;
      if (!(abort_at > 0 && t >= abort_at) && is_rd && ok && d >= 1 &&
          d <= TX_TIMEOUT && t > d && t <= d + 8)
        exp_miso = val[7-(t-d-1)];
      check("miso", MISO, exp_miso);
      if (t == 1) begin
        check("rx_valid_one_cycle", rx_valid, 0);
        check("err_quiet", err, 0);
      end
      if (t == abort_at) break;
    end
    if (is_rd && ok) rd_seen = 1'b0;

    tx_valid = 1'b0;
    SS_n     = 1'b1;
    tick();
    check("miso_idle", MISO, 0);
    check("rx_valid_idle", rx_valid, 0);
    check("err_idle", err, 0);
  endtask

  task automatic partial_frame(input logic [9:0] w, input int n);
    SS_n = 1'b0;
    tick();
    for (int i = 0; i < n; i++) begin
      MOSI = w[9-i];
      tick();
      check("rx_valid_partial", rx_valid, 0);
    end
    SS_n = 1'b1;
    tick();
    check("rx_valid_abort", rx_valid, 0);
    check("err_abort", err, err_expected_on_partial());
    tick();
    check("err_after_abort", err, 0);
  endtask

  task automatic reset_mid_frame(input logic [9:0] w, input int n);
    SS_n = 1'b0;
    tick();
    for (int i = 0; i < n; i++) begin
      MOSI = w[9-i];
      tick();
    end
    rst = 1'b1;
    tick();
    check("rst_mid_rx_valid", rx_valid, 0);
    check("rst_mid_miso", MISO, 0);
    check("rst_mid_err", err, 0);
    rd_seen = 1'b0;
    rst  = 1'b0;
    SS_n = 1'b1;
    tick();
  endtask

  initial begin
    logic [9:0] w;
    int         kind;
    int         ab;

    rst      = 1'b1;
    SS_n     = 1'b0;
    MOSI     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    rd_seen  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      MOSI = ~MOSI;
      tick();
      check("reset_rx_valid", rx_valid, 0);
      check("reset_miso", MISO, 0);
      check("reset_err", err, 0);
    end
    rst  = 1'b0;
    SS_n = 1'b1;
    tick();

    full_frame(10'h0A5, 0, 0, 8'h00);   // write address
    full_frame(10'h23C, 0, 0, 8'h00);   // read address
    full_frame(10'h300, 2, 0, 8'hC3);   // read data, MISO 1100_0011
    partial_frame(10'h3FF, 6);
    full_frame(10'h1F0, 0, 0, 8'h00);
    full_frame(10'h2AA, 0, 0, 8'h00);   // read address
    full_frame(10'h3FF, 0, 0, 8'h00);   // read data, timeout
    full_frame(10'h255, 2, 0, 8'hC3);   // back in READ_ADD: no MISO
    full_frame(10'h3A5, 1, 6, 8'hFF);   // read data aborted mid-shift
    full_frame(10'h301, 2, 0, 8'hA5);   // opcode mismatch when checking is enabled
    full_frame(10'h2F0, 2, 0, 8'hA5);
    full_frame(10'h3F0, 4, 0, 8'h96);   // last cycle of the wait window
    full_frame(10'h211, 0, 0, 8'h00);
    full_frame(10'h311, 5, 0, 8'h96);   // tx_valid just past the window
    full_frame(10'h23C, 0, 0, 8'h00);
    reset_mid_frame(10'h3C3, 5);        // clears pending address
    full_frame(10'h3C3, 2, 0, 8'h5A);   // must route to READ_ADD

    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 9);
      w    = 10'($urandom);
      if ($urandom_range(0, 2) != 0) w[9] = 1'b1;
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 16) : 0;
      if (kind == 0)      partial_frame(w, $urandom_range(1, 9));
      else if (kind == 1) reset_mid_frame(w, $urandom_range(0, 9));
      else                full_frame(w, $urandom_range(0, 7), ab, 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_fsm.md
Name: spi_slave_fsm

Overview:
- Serial front end of the SPI slave; sits directly upstream of the single-port RAM and feeds it.
- Deserialises MOSI frames into 10-bit command words and presents them on rx_data/rx_valid, which drive the RAM's din/rx_valid.
- Captures RAM read data on tx_data/tx_valid and serialises it onto MISO.
- Runs on the same clk as the RAM. One serial bit per clk while SS_n is low.

Parameters:
- ADDR_SIZE, 8, RAM address width. rx_data width is ADDR_SIZE+2.
- MEM_WIDTH, 8, RAM data width. Number of bits shifted out on MISO.
- TX_TIMEOUT, 4, maximum clk cycles to wait for tx_valid after a read-data frame.

Ports:
- clk  in  1  system/serial clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- SS_n  in  1  slave select, active low.
- MOSI  in  1  serial data in, MSB first, sampled on rising clk.
- MISO  out  1  serial data out, MSB first.
- rx_data  out  ADDR_SIZE+2  command word to RAM. [9:8] is the opcode: 00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data.
- rx_valid  out  1  one-cycle strobe; rx_data is valid.
- tx_data  in  MEM_WIDTH  RAM read data.
- tx_valid  in  1  tx_data valid, sampled for one cycle.
- err  out  1  one-cycle protocol-error strobe; tied 0 unless the optional feature is enabled.

Behaviour:
- Reset (rst=1 at posedge) clears the following:
  - state=IDLE; rx_data=0; rx_valid=0; MISO=0; err=0.
  - bit counter=0; rd_addr_seen flag=0; tx shift register=0.
- FSM states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: MISO=0. SS_n=0 -> CHK_CMD, with no bit sampled in this cycle.
- CHK_CMD: samples MOSI as rx bit 9 and sets count=1. Next state:
  - MOSI=0 -> WRITE.
  - MOSI=1 and rd_addr_seen=0 -> READ_ADD.
  - MOSI=1 and rd_addr_seen=1 -> READ_DATA.
- WRITE / READ_ADD / READ_DATA receive phase:
  - Shift MOSI in MSB-first each cycle until count reaches ADDR_SIZE+2 (10).
  - The cycle after the 10th bit is sampled: rx_data=shift register and rx_valid=1 for exactly one cycle. After that, rx_valid=0.
  - Latency from the last MOSI bit to rx_valid is 1 cycle.
  - READ_ADD frame complete: rd_addr_seen<=1.
  - Extra MOSI bits after the 10th are ignored. The state is held until SS_n=1.
- READ_DATA transmit phase, after rx_valid:
  - Wait for tx_valid=1, for at most TX_TIMEOUT cycles.
  - On tx_valid: load tx_data, then drive MISO with bits 7..0 on the next 8 consecutive cycles, one per clk.
  - Then MISO=0 and rd_addr_seen<=0.
  - Timeout: MISO stays 0; rd_addr_seen<=0.
  - tx_valid outside the wait window is ignored.
- SS_n=1 in any non-IDLE state -> IDLE on the next edge. Count is cleared.
  - Partial frame (fewer than 10 bits): no rx_valid is issued and rd_addr_seen is unchanged.
  - Abort during the MISO shift: MISO=0 immediately on the next edge and rd_addr_seen<=0.
- rx_valid never coincides with SS_n=1 sampled in the same cycle as bit 10. The frame counts only if all 10 bits are sampled with SS_n=0.
- rst mid-frame overrides everything: the reset values above apply on that edge.

Optional Feature:
- Macro: SPI_CMD_CHECK_EN.
- Enabled: at frame completion, rx_data[9:8] is checked against the state:
  - WRITE requires 0x.
  - READ_ADD requires 10.
  - READ_DATA requires 11.
  - On mismatch, rx_valid is suppressed, err=1 for one cycle, and rd_addr_seen is unchanged.
  - A partial frame aborted by SS_n also pulses err on the IDLE transition edge.
- Disabled: no checks. err is constant 0, and any completed frame issues rx_valid.

Test Plan:
- Reset: rst=1 for 2 cycles with SS_n=0 and MOSI toggling -> rx_valid=0, MISO=0, err=0, state IDLE.
- Write address: SS_n low, MOSI=00_1010_0101 -> rx_data=0x0A5 with rx_valid high for exactly 1 cycle, 1 cycle after the 10th bit.
- Read sequence:
  - Frame 10_0011_1100 -> rx_data=0x23C.
  - SS_n high, then frame 11_0000_0000 -> rx_data=0x300.
  - Bench returns tx_valid with tx_data=0xC3 two cycles later -> MISO sequence 1,1,0,0,0,0,1,1, then 0.
- Abort: SS_n rises after 6 bits -> no rx_valid, FSM in IDLE. The next full frame 01_1111_0000 -> rx_data=0x1F0.
- Timeout: rd-data frame with no tx_valid for 4 cycles -> MISO stays 0. The next MOSI=1 frame goes to READ_ADD.
- SPI_CMD_CHECK_EN: in READ_ADD, send 11_0000_0001 -> no rx_valid, err pulses once, and the next MOSI=1 frame still enters READ_ADD.
